fir_mac_sequencer: RTL

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

---
 rtl/fir_mac_sequencer_if.sv | 35 +++
 rtl/fir_mac_sequencer.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/fir_mac_sequencer_if.sv
// Handshake and RAM/MAC control bundle between a FIR sample source and the MAC sequencer.
// Latency: none, wires only.
// Backpressure: in_ready/cfg_ready are driven by the sequencer; the master holds requests until accepted.
interface fir_mac_sequencer_if #(
    parameter int AW = 2
);
    logic          sample_valid;
    logic          in_ready;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic          cfg_ready;
    logic          flush;
    logic          smp_we;
    logic          smp_zero;
    logic [AW-1:0] smp_addr;
    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic          mac_en;
    logic          mac_clr;
    logic          out_valid;

    // Request side: offers samples, coefficient writes and flushes.
    modport master (
        output sample_valid, cfg_we, cfg_addr, flush,
        input  in_ready, cfg_ready, smp_we, smp_zero, smp_addr,
               coef_we, coef_addr, mac_en, mac_clr, out_valid
    );

    // Sequencer side: accepts requests and drives RAM/MAC control.
    modport slave (
        input  sample_valid, cfg_we, cfg_addr, flush,
        output in_ready, cfg_ready, smp_we, smp_zero, smp_addr,
               coef_we, coef_addr, mac_en, mac_clr, out_valid
    );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Sequences sample-RAM writes, coefficient writes and TAPS MAC cycles for a time-multiplexed FIR.
// Latency: sample accepted at cycle 0 gives out_valid at cycle TAPS+2; one sample per TAPS+3 cycles.
// Backpressure: in_ready/cfg_ready high only in IDLE; requests outside IDLE are ignored, not queued.
module fir_mac_sequencer #(
    parameter int TAPS = 4,
    parameter int AW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    fir_mac_sequencer_if.slave   bus
);

    typedef enum logic [2:0] {
        S_INIT = 3'd0,
        S_IDLE = 3'd1,
        S_LOAD = 3'd2,
        S_MAC  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [AW-1:0] LAST   = AW'(TAPS - 1);
    // Modulo-2^AW image of TAPS; zero when TAPS is a power of two, which still wraps correctly.
    localparam logic [AW-1:0] TAPS_A = AW'(TAPS);

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] mac_addr;
    logic          accept;

    // Newest sample sits at wr_ptr; tap k reads (wr_ptr - k) mod TAPS. The true result is
    // below TAPS, so AW-bit wrapping arithmetic yields it exactly.
    always_comb begin
        if (wr_ptr_q >= cnt_q) begin
            mac_addr = wr_ptr_q - cnt_q;
        end else begin
            mac_addr = wr_ptr_q - cnt_q + TAPS_A;
        end
    end

    // Sample taken only in IDLE when neither a flush nor a coefficient write claims the cycle.
    assign accept = (state_q == S_IDLE) && !bus.flush && !bus.cfg_we && bus.sample_valid;

    // State, counter and write-pointer registers; reset restarts the zero-fill sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_INIT;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Next-state logic: INIT and MAC each run TAPS counted cycles, LOAD and DONE one cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        case (state_q)
            S_INIT: begin
                if (cnt_q == LAST) begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    wr_ptr_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (bus.flush) begin
                    state_d  = S_INIT;
                    cnt_d    = '0;
                    wr_ptr_d = '0;
                end else if (accept) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_MAC;
                cnt_d   = '0;
            end
            S_MAC: begin
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
            end
            default: begin
                state_d  = S_INIT;
                cnt_d    = '0;
                wr_ptr_d = '0;
            end
        endcase
    end

    // Output decode straight from state, counter and inputs, with no register stage.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.cfg_ready = 1'b0;
        bus.smp_we    = 1'b0;
        bus.smp_zero  = 1'b0;
        bus.smp_addr  = wr_ptr_q;
        bus.coef_we   = 1'b0;
        bus.coef_addr = bus.cfg_addr;
        bus.mac_en    = 1'b0;
        bus.mac_clr   = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            S_INIT: begin
                bus.smp_we   = 1'b1;
                bus.smp_zero = 1'b1;
                bus.smp_addr = cnt_q;
            end
            S_IDLE: begin
                // A flush takes the whole cycle: nothing is accepted alongside it.
                bus.cfg_ready = !bus.flush;
                bus.in_ready  = !bus.flush && !bus.cfg_we;
                bus.coef_we   = !bus.flush && bus.cfg_we;
            end
            S_LOAD: begin
                bus.smp_we = 1'b1;
            end
            S_MAC: begin
                bus.mac_en    = 1'b1;
                bus.mac_clr   = (cnt_q == '0);
                bus.coef_addr = cnt_q;
                bus.smp_addr  = mac_addr;
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
            end
            default: begin
                bus.in_ready = 1'b0;
            end
        endcase
    end

endmodule
